// File: rtl/irq_pkg.sv
// Shared types and helpers for the priority interrupt arbiter.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    ACK   = 2'd2
  } irq_state_t;

  localparam int          MAX_SRC        = 8;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0800;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0004;

  // Index of the lowest set bit; 0 when no bit is set (callers qualify with "any").
  function automatic logic [2:0] lowest_set_idx(input logic [MAX_SRC-1:0] v);
    lowest_set_idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: bit 0 has the highest priority.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  logic [MAX_SRC-1:0] req_ext;

  assign req_ext = MAX_SRC'(req);
  assign any     = |req;
  assign idx     = ID_W'(lowest_set_idx(req_ext));

endmodule

// File: rtl/irq_arbiter.sv
// Priority interrupt arbiter: edge-latched requests, masking, nested preemption
// and a valid/ack handshake that offers a frozen id/vector to the core.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int          NUM_SRC    = 3,
  parameter int          ID_W       = 2,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               global_ie,
  input  logic               irq_ack,
  input  logic               irq_eret,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [31:0]        irq_vector,
  output logic [NUM_SRC-1:0] in_service,
  output logic [NUM_SRC-1:0] pending
);

  irq_state_t         state, state_nxt;
  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_bit;
  logic [NUM_SRC-1:0] eret_bit;
  logic               win_any, ins_any;
  logic [ID_W-1:0]    win_idx, ins_idx;
  logic [ID_W:0]      top_lim;
  logic               valid_d;
  logic               latch_win;

  assign rise = irq_req & ~req_q;

  irq_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_win_enc (
    .req (eligible),
    .any (win_any),
    .idx (win_idx)
  );

  irq_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_top_enc (
    .req (in_service),
    .any (ins_any),
    .idx (ins_idx)
  );

  // Only a source strictly above the innermost active handler may preempt it.
  always_comb begin
    top_lim = ins_any ? {1'b0, ins_idx} : (ID_W + 1)'(NUM_SRC);
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending[i] & ~irq_mask[i] & global_ie & ((ID_W + 1)'(i) < top_lim);
    end
  end

  assign ack_bit  = (state == ACK) ? (NUM_SRC'(1) << irq_id) : '0;
  assign eret_bit = (irq_eret && ins_any) ? (NUM_SRC'(1) << ins_idx) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_any) state_nxt = OFFER;
      OFFER:   if (irq_ack) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_d   = (state_nxt == OFFER);
    latch_win = (state == IDLE) && win_any;
  end

  // Outputs are registered; the offered id/vector only change when leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_valid  <= 1'b0;
      irq_id     <= '0;
      irq_vector <= VEC_BASE;
    end else begin
      irq_valid <= valid_d;
      if (latch_win) begin
        irq_id     <= win_idx;
        irq_vector <= VEC_BASE + 32'(win_idx) * VEC_STRIDE;
      end
    end
  end

  // A new rise beats the ACK clear; an eret clear precedes the ACK set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      pending    <= '0;
      in_service <= '0;
    end else begin
      req_q      <= irq_req;
      pending    <= (pending & ~ack_bit) | rise;
      in_service <= (in_service & ~eret_bit) | ack_bit;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: stimulus queues expected offers, a monitor
// checks each offer as irq_valid rises.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  irq_req, irq_mask;
  logic        global_ie, irq_ack, irq_eret;
  logic        irq_valid;
  logic [1:0]  irq_id;
  logic [31:0] irq_vector;
  logic [2:0]  in_service, pending;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] vec;
  } offer_t;

  offer_t exp_q[$];
  int     n_cmp  = 0;
  int     n_fail = 0;
  logic   seen   = 1'b0;

  irq_arbiter #(.NUM_SRC(3), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_req    (irq_req),
    .irq_mask   (irq_mask),
    .global_ie  (global_ie),
    .irq_ack    (irq_ack),
    .irq_eret   (irq_eret),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_vector (irq_vector),
    .in_service (in_service),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_offer(input logic [1:0] id, input logic [31:0] vec);
    offer_t o;
    o.id  = id;
    o.vec = vec;
    exp_q.push_back(o);
  endtask

  task automatic req(input int i);
    irq_req[i] = 1'b1;
    tick();
    irq_req[i] = 1'b0;
  endtask

  task automatic ack_seq();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ack_drops_valid", {31'b0, irq_valid}, 32'd0);
    tick();
  endtask

  task automatic eret();
    irq_eret = 1'b1;
    tick();
    irq_eret = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!irq_valid && k < max) begin
      tick();
      k++;
    end
    check("wait_valid", {31'b0, irq_valid}, 32'd1);
  endtask

  // Monitor: one scoreboard pop per offer.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (irq_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_offer: got id %0d expected none at %0t", irq_id, $time);
      end else begin
        offer_t o;
        o = exp_q.pop_front();
        check("offer_id", {30'b0, irq_id}, {30'b0, o.id});
        check("offer_vec", irq_vector, o.vec);
      end
    end else if (!irq_valid) begin
      seen = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; irq_req = '0; irq_mask = '0; global_ie = 1'b1;
    irq_ack = 1'b0; irq_eret = 1'b0;
    tick(3);
    rst_n = 1'b1;
    check("rst_valid", {31'b0, irq_valid}, 32'd0);
    check("rst_id", {30'b0, irq_id}, 32'd0);
    check("rst_vec", irq_vector, 32'h800);
    check("rst_insvc", {29'b0, in_service}, 32'd0);
    check("rst_pending", {29'b0, pending}, 32'd0);

    // Single request with two-cycle latency
    expect_offer(2'd1, 32'h804);
    req(1);
    check("t1_pending", {29'b0, pending}, 32'b010);
    check("t1_not_yet", {31'b0, irq_valid}, 32'd0);
    tick();
    check("t1_latency", {31'b0, irq_valid}, 32'd1);
    ack_seq();
    check("t1_pending_clr", {29'b0, pending}, 32'b000);
    check("t1_insvc", {29'b0, in_service}, 32'b010);
    eret();
    check("t1_eret", {29'b0, in_service}, 32'b000);

    // Priority: simultaneous 0 and 2
    expect_offer(2'd0, 32'h800);
    irq_req = 3'b101;
    tick();
    irq_req = 3'b000;
    tick();
    check("t2_valid", {31'b0, irq_valid}, 32'd1);
    ack_seq();
    check("t2_pending", {29'b0, pending}, 32'b100);
    check("t2_insvc", {29'b0, in_service}, 32'b001);
    tick(2);
    check("t2_blocked", {31'b0, irq_valid}, 32'd0);
    expect_offer(2'd2, 32'h808);
    eret();
    tick();
    check("t2_after_eret", {31'b0, irq_valid}, 32'd1);
    ack_seq();
    eret();

    // Nesting
    expect_offer(2'd1, 32'h804);
    req(1);
    tick();
    ack_seq();
    expect_offer(2'd0, 32'h800);
    req(0);
    tick();
    check("t3_preempt", {31'b0, irq_valid}, 32'd1);
    ack_seq();
    check("t3_insvc2", {29'b0, in_service}, 32'b011);
    req(2);
    tick(3);
    check("t3_no_offer", {31'b0, irq_valid}, 32'd0);
    check("t3_pending2", {29'b0, pending}, 32'b100);
    eret();
    check("t3_eret1", {29'b0, in_service}, 32'b010);
    tick();
    check("t3_still_blocked", {31'b0, irq_valid}, 32'd0);
    expect_offer(2'd2, 32'h808);
    eret();
    check("t3_eret2", {29'b0, in_service}, 32'b000);
    tick();
    check("t3_src2_offer", {31'b0, irq_valid}, 32'd1);
    ack_seq();
    eret();

    // Masking and global enable
    irq_mask = 3'b010;
    req(1);
    check("t4_masked_pend", {29'b0, pending}, 32'b010);
    tick(2);
    check("t4_masked_idle", {31'b0, irq_valid}, 32'd0);
    expect_offer(2'd1, 32'h804);
    irq_mask = 3'b000;
    wait_valid(4);
    ack_seq();
    eret();
    global_ie = 1'b0;
    req(2);
    tick(3);
    check("t4_ie_off", {31'b0, irq_valid}, 32'd0);
    check("t4_ie_pend", {29'b0, pending}, 32'b100);
    expect_offer(2'd2, 32'h808);
    global_ie = 1'b1;
    wait_valid(4);
    ack_seq();
    eret();

    // Frozen offer
    expect_offer(2'd2, 32'h808);
    req(2);
    tick();
    req(0);
    tick(2);
    check("t5_frozen_id", {30'b0, irq_id}, 32'd2);
    check("t5_frozen_vec", irq_vector, 32'h808);
    check("t5_pending", {29'b0, pending}, 32'b101);
    expect_offer(2'd0, 32'h800);
    ack_seq();
    check("t5_insvc", {29'b0, in_service}, 32'b100);
    tick();
    check("t5_next_offer", {31'b0, irq_valid}, 32'd1);
    ack_seq();
    check("t5_nested", {29'b0, in_service}, 32'b101);
    eret();
    eret();
    check("t5_cleared", {29'b0, in_service}, 32'b000);

    // Eret and re-rise coinciding with ACK bookkeeping
    expect_offer(2'd1, 32'h804);
    req(1);
    tick();
    ack_seq();
    expect_offer(2'd0, 32'h800);
    req(0);
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eret = 1'b1;
    irq_req[0] = 1'b1;
    tick();
    irq_eret = 1'b0;
    irq_req[0] = 1'b0;
    check("t6_eret_ack", {29'b0, in_service}, 32'b001);
    check("t6_set_wins", {29'b0, pending}, 32'b001);
    tick(2);
    check("t6_self_blocked", {31'b0, irq_valid}, 32'd0);
    expect_offer(2'd0, 32'h800);
    eret();
    tick();
    check("t6_reoffer", {31'b0, irq_valid}, 32'd1);
    ack_seq();
    eret();

    // Corner cases: eret and ack while idle
    eret();
    check("t7_eret_empty", {29'b0, in_service}, 32'b000);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    check("t7_ack_idle_v", {31'b0, irq_valid}, 32'd0);
    check("t7_ack_idle_s", {29'b0, in_service}, 32'b000);

    // Asynchronous reset mid-OFFER
    expect_offer(2'd1, 32'h804);
    req(1);
    tick();
    check("t8_offer", {31'b0, irq_valid}, 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t8_rst_valid", {31'b0, irq_valid}, 32'd0);
    check("t8_rst_id", {30'b0, irq_id}, 32'd0);
    check("t8_rst_vec", irq_vector, 32'h800);
    check("t8_rst_pend", {29'b0, pending}, 32'b000);
    check("t8_rst_insvc", {29'b0, in_service}, 32'b000);
    tick();
    rst_n = 1'b1;
    tick(3);
    check("t8_quiet", {31'b0, irq_valid}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
